// File: rtl/core_seq_ctrl_pkg.sv
// Shared types and constants for the npc core sequencer: state encoding,
// special instruction words and the major opcodes seen by the control decoder.
package core_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH_REQ  = 3'd0,
    ST_FETCH_WAIT = 3'd1,
    ST_EXEC       = 3'd2,
    ST_MEM_REQ    = 3'd3,
    ST_MEM_WAIT   = 3'd4,
    ST_WB         = 3'd5,
    ST_HALT       = 3'd6
  } seq_state_e;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_NOP    = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;

  // States in which the handshake timer runs.
  function automatic logic is_wait_state(seq_state_e s);
    return (s == ST_FETCH_REQ) || (s == ST_FETCH_WAIT) ||
           (s == ST_MEM_REQ)   || (s == ST_MEM_WAIT);
  endfunction

endpackage

// File: rtl/core_seq_ctrl_if.sv
// Instruction/data memory handshakes plus the decoder loop (ir out, decode bits back).
// master = sequencer side, slave = memory/decoder side.
interface core_seq_ctrl_if;
  logic        if_req_valid;
  logic        if_req_ready;
  logic        if_resp_valid;
  logic [31:0] if_resp_data;
  logic [31:0] ir;
  logic        dec_mem_r;
  logic        dec_mem_w;
  logic        dec_reg_w;
  logic        ls_req_valid;
  logic        ls_req_we;
  logic        ls_req_ready;
  logic        ls_resp_valid;

  modport master (
    output if_req_valid, ir, ls_req_valid, ls_req_we,
    input  if_req_ready, if_resp_valid, if_resp_data,
    input  dec_mem_r, dec_mem_w, dec_reg_w,
    input  ls_req_ready, ls_resp_valid
  );

  modport slave (
    input  if_req_valid, ir, ls_req_valid, ls_req_we,
    output if_req_ready, if_resp_valid, if_resp_data,
    output dec_mem_r, dec_mem_w, dec_reg_w,
    output ls_req_ready, ls_resp_valid
  );
endinterface

// File: rtl/core_seq_ctrl_seq_wait_timer.sv
// Per-state wait timer: reloads on clear, counts down while enabled and
// flags expiry on the TIMEOUT_CYCLES-th enabled cycle since the last clear.
module seq_wait_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TC_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= TC_LOAD;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle fetch/execute/memory/writeback sequencer for the npc RV64 core.
// Owns the instruction register, cycle/instret counters and sticky halt/timeout.
//
//   state      | meaning
//   FETCH_REQ  | if_req_valid high, waiting for if_req_ready
//   FETCH_WAIT | waiting for if_resp_valid, then latch ir
//   EXEC       | decoder settles on ir; pick HALT / MEM_REQ / WB
//   MEM_REQ    | ls_req_valid high, waiting for ls_req_ready
//   MEM_WAIT   | waiting for ls_resp_valid
//   WB         | pc_we, rf_we if decoder writes rd, retire
//   HALT       | absorbing until rst
module core_seq_ctrl
  import core_seq_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 64
) (
  input  logic             clk,
  input  logic             rst,
  core_seq_ctrl_if.master  bus,
  output logic             pc_we,
  output logic             rf_we,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  seq_state_e  state;
  seq_state_e  state_nxt;
  logic [31:0] ir_q;
  logic        timer_exp;
  logic        tmo_hit;

  seq_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_nxt != state),
    .enable  (is_wait_state(state)),
    .expired (timer_exp)
  );

  // Exit conditions are checked before expiry so a same-cycle handshake wins.
  always_comb begin
    state_nxt = state;
    tmo_hit   = 1'b0;
    unique case (state)
      ST_FETCH_REQ:  if (bus.if_req_ready) state_nxt = ST_FETCH_WAIT;
                     else if (timer_exp)   tmo_hit   = 1'b1;
      ST_FETCH_WAIT: if (bus.if_resp_valid) state_nxt = ST_EXEC;
                     else if (timer_exp)    tmo_hit   = 1'b1;
      ST_EXEC:       if (ir_q == INST_EBREAK)               state_nxt = ST_HALT;
                     else if (bus.dec_mem_w || bus.dec_mem_r) state_nxt = ST_MEM_REQ;
                     else                                    state_nxt = ST_WB;
      ST_MEM_REQ:    if (bus.ls_req_ready) state_nxt = ST_MEM_WAIT;
                     else if (timer_exp)   tmo_hit   = 1'b1;
      ST_MEM_WAIT:   if (bus.ls_resp_valid) state_nxt = ST_WB;
                     else if (timer_exp)    tmo_hit   = 1'b1;
      ST_WB:         state_nxt = ST_FETCH_REQ;
      ST_HALT:       state_nxt = ST_HALT;
      default:       state_nxt = ST_FETCH_REQ;
    endcase
    if (tmo_hit) state_nxt = ST_HALT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_FETCH_REQ;
      ir_q        <= INST_NOP;
      timeout     <= 1'b0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ST_FETCH_WAIT) && bus.if_resp_valid) ir_q <= bus.if_resp_data;
      if (tmo_hit) timeout <= 1'b1;
      if (state != ST_HALT) cycle_cnt <= cycle_cnt + 1'b1;
      if (state == ST_WB) instret_cnt <= instret_cnt + 1'b1;
    end
  end

  // Strobes are forced low during reset even though state already reads FETCH_REQ.
  assign bus.ir           = ir_q;
  assign bus.if_req_valid = !rst && (state == ST_FETCH_REQ);
  assign bus.ls_req_valid = !rst && (state == ST_MEM_REQ);
  assign bus.ls_req_we    = bus.ls_req_valid && bus.dec_mem_w;
  assign pc_we            = !rst && (state == ST_WB);
  assign rf_we            = pc_we && bus.dec_reg_w;
  assign halted           = (state == ST_HALT);

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: directed instruction table, ebreak/timeout/reset
// corner sequences, then a randomized stream against a latency/retire model.
module tb_core_seq_ctrl;
  import core_seq_ctrl_pkg::*;

  localparam int TMO   = 8;
  localparam int CNT_W = 64;

  localparam logic [31:0] I_ADDI = 32'h0010_0093;
  localparam logic [31:0] I_LW   = 32'h0000_a103;
  localparam logic [31:0] I_SW   = 32'h0020_a023;
  localparam logic [31:0] I_BEQ  = 32'h0000_0063;
  localparam logic [31:0] I_LUI  = 32'h1234_50b7;

  logic             clk = 1'b0;
  logic             rst;
  logic             pc_we, rf_we, halted, timeout;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;
  logic             dec_force_r;
  logic [6:0]       opc;

  core_seq_ctrl_if bus();

  core_seq_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .pc_we       (pc_we),
    .rf_we       (rf_we),
    .halted      (halted),
    .timeout     (timeout),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  always #5 clk = ~clk;

  // Stand-in control decoder; dec_force_r lets a store also claim mem_r.
  assign opc           = bus.ir[6:0];
  assign bus.dec_mem_r = (opc == OPC_LOAD) || dec_force_r;
  assign bus.dec_mem_w = (opc == OPC_STORE);
  assign bus.dec_reg_w = (opc == OPC_LOAD) || (opc == OPC_OP_IMM) || (opc == OPC_LUI);

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] smp_cyc, smp_ins;
  logic [31:0] smp_ir;
  longint      cyc_base, model_ins;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic nzf(input logic on);
    return on ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  // One clock: drive inputs at negedge, check outputs, advance to posedge.
  // exp bits: if_req_valid, ls_req_valid, ls_req_we, pc_we, rf_we, halted
  task automatic step(input logic ifr, input logic ifv, input logic [31:0] d,
                      input logic lsr, input logic lsv, input logic [5:0] exp,
                      input string tag);
    @(negedge clk);
    rst               = 1'b0;
    bus.if_req_ready  = ifr;
    bus.if_resp_valid = ifv;
    bus.if_resp_data  = d;
    bus.ls_req_ready  = lsr;
    bus.ls_resp_valid = lsv;
    #1;
    chk(tag, 64'({bus.if_req_valid, bus.ls_req_valid, bus.ls_req_we, pc_we, rf_we, halted}),
        64'(exp));
    smp_cyc = cycle_cnt;
    smp_ins = instret_cnt;
    smp_ir  = bus.ir;
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst               = 1'b1;
    bus.if_req_ready  = 1'b0;
    bus.if_resp_valid = 1'b0;
    bus.if_resp_data  = '0;
    bus.ls_req_ready  = 1'b0;
    bus.ls_resp_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_outs", 64'({bus.if_req_valid, bus.ls_req_valid, bus.ls_req_we, pc_we, rf_we, halted}), 64'd0);
    chk("rst_ir", 64'(bus.ir), 64'(INST_NOP));
    chk("rst_cycle", cycle_cnt, 64'd0);
    chk("rst_instret", instret_cnt, 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    @(posedge clk);
    cyc_base  = 0;
    model_ins = 0;
  endtask

  // Runs one instruction with s1/d1 fetch and s2/d2 data-side stall cycles.
  task automatic run_instr(input logic [31:0] insn, input int s1, input int d1,
                           input int s2, input int d2, input logic nz, input logic both,
                           output int lat);
    logic ld, st, mem, rw;
    int   lat_exp;
    logic [63:0] c0;
    ld  = (insn[6:0] == OPC_LOAD);
    st  = (insn[6:0] == OPC_STORE);
    mem = ld || st;
    rw  = ld || (insn[6:0] == OPC_OP_IMM) || (insn[6:0] == OPC_LUI);
    lat_exp = s1 + d1 + 4 + (mem ? (s2 + d2 + 2) : 0);
    dec_force_r = both;
    c0 = '0;
    for (int k = 0; k <= s1; k++) begin
      step(k == s1, nzf(nz), $urandom, nzf(nz), nzf(nz), 6'b100000, "fetch_req");
      if (k == 0) c0 = smp_cyc;
    end
    for (int k = 0; k <= d1; k++)
      step(nzf(nz), k == d1, (k == d1) ? insn : $urandom, nzf(nz), nzf(nz), 6'b000000, "fetch_wait");
    step(nzf(nz), nzf(nz), $urandom, nzf(nz), nzf(nz), 6'b000000, "exec");
    chk("exec_ir", 64'(smp_ir), 64'(insn));
    if (mem) begin
      for (int k = 0; k <= s2; k++)
        step(nzf(nz), nzf(nz), $urandom, k == s2, nzf(nz), {2'b01, st, 3'b000}, "mem_req");
      for (int k = 0; k <= d2; k++)
        step(nzf(nz), nzf(nz), $urandom, nzf(nz), k == d2, 6'b000000, "mem_wait");
    end
    step(nzf(nz), nzf(nz), $urandom, nzf(nz), nzf(nz), {3'b000, 1'b1, rw, 1'b0}, "wb");
    chk("wb_cycle_cnt", smp_cyc, 64'(cyc_base + lat_exp - 1));
    chk("wb_instret", smp_ins, 64'(model_ins));
    lat = int'(smp_cyc - c0) + 1;
    cyc_base  += lat_exp;
    model_ins += 1;
    dec_force_r = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [31:0] insn;
    int          s1, d1, s2, d2;
    logic        both;
    int          exp_lat;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic [31:0] pool[5];
    rst = 1'b1;
    dec_force_r = 1'b0;
    bus.if_req_ready = 1'b0; bus.if_resp_valid = 1'b0; bus.if_resp_data = '0;
    bus.ls_req_ready = 1'b0; bus.ls_resp_valid = 1'b0;

    tbl[0] = '{"addi_a",    I_ADDI, 0, 0, 0, 0, 1'b0, 4};
    tbl[1] = '{"addi_b",    I_ADDI, 0, 0, 0, 0, 1'b0, 4};
    tbl[2] = '{"addi_c",    I_ADDI, 0, 0, 0, 0, 1'b0, 4};
    tbl[3] = '{"lw",        I_LW,   0, 0, 0, 0, 1'b0, 6};
    tbl[4] = '{"sw_stall3", I_SW,   0, 0, 3, 0, 1'b0, 9};
    tbl[5] = '{"beq",       I_BEQ,  0, 0, 0, 0, 1'b0, 4};
    tbl[6] = '{"lui_stall", I_LUI,  2, 1, 0, 0, 1'b0, 7};
    tbl[7] = '{"lw_expiry", I_LW,   0, 0, 0, 7, 1'b0, 13};
    tbl[8] = '{"sw_allmax", I_SW,   7, 7, 7, 7, 1'b0, 34};
    tbl[9] = '{"st_and_ld", I_SW,   0, 0, 0, 0, 1'b1, 6};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_instr(tbl[i].insn, tbl[i].s1, tbl[i].d1, tbl[i].s2, tbl[i].d2, 1'b0, tbl[i].both, lat);
      chk({tbl[i].name, "_lat"}, 64'(lat), 64'(tbl[i].exp_lat));
      if (i == 2) begin
        #1;
        chk("instret_after_12", instret_cnt, 64'd3);
        chk("cycle_after_12", cycle_cnt, 64'd12);
      end
    end
    chk("tbl_timeout", 64'(timeout), 64'd0);
    chk("tbl_halted", 64'(halted), 64'd0);

    // ebreak: halts after EXEC without retiring, cycle count frozen
    do_reset();
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 6'b100000, "eb_fetch_req");
    step(1'b0, 1'b1, INST_EBREAK, 1'b0, 1'b0, 6'b000000, "eb_fetch_wait");
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 6'b000000, "eb_exec");
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, I_ADDI, 1'b1, 1'b1, 6'b000001, "eb_halt");
      chk("eb_cycle_frozen", smp_cyc, 64'd3);
      chk("eb_instret", smp_ins, 64'd0);
    end
    chk("eb_timeout", 64'(timeout), 64'd0);

    // fetch response never arrives: 8 cycles in FETCH_WAIT then timeout halt
    do_reset();
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 6'b100000, "to_fetch_req");
    for (int k = 0; k < TMO; k++)
      step(1'b0, 1'b0, '0, 1'b1, 1'b1, 6'b000000, "to_fetch_wait");
    step(1'b0, 1'b1, I_ADDI, 1'b0, 1'b0, 6'b000001, "to_halt");
    chk("to_timeout", 64'(timeout), 64'd1);
    chk("to_cycle", smp_cyc, 64'd9);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 6'b000001, "to_halt2");
    chk("to_cycle_frozen", smp_cyc, 64'd9);

    // randomized stream with noise on ignored inputs
    pool = '{I_ADDI, I_LW, I_SW, I_BEQ, I_LUI};
    do_reset();
    for (int i = 0; i < 40; i++)
      run_instr(pool[$urandom_range(0, 4)], $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 7), 1'b1, 1'b0, lat);
    #1;
    chk("rand_instret", instret_cnt, 64'd40);
    chk("rand_timeout", 64'(timeout), 64'd0);

    // reset while in MEM_WAIT, stale response in the first cycle after
    do_reset();
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 6'b100000, "mr_fetch_req");
    step(1'b0, 1'b1, I_LW, 1'b0, 1'b0, 6'b000000, "mr_fetch_wait");
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 6'b000000, "mr_exec");
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 6'b010000, "mr_mem_req");
    @(negedge clk);
    rst = 1'b1;
    bus.ls_req_ready = 1'b0;
    #1;
    chk("mr_rst_outs", 64'({bus.if_req_valid, bus.ls_req_valid, bus.ls_req_we, pc_we, rf_we, halted}), 64'd0);
    @(posedge clk);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 6'b100000, "mr_stale_resp");
    chk("mr_ir", 64'(smp_ir), 64'(INST_NOP));
    chk("mr_cycle", smp_cyc, 64'd0);
    chk("mr_instret", smp_ins, 64'd0);
    cyc_base  = 1;
    model_ins = 0;
    run_instr(I_ADDI, 0, 0, 0, 0, 1'b0, 1'b0, lat);
    chk("mr_addi_lat", 64'(lat), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
